branch_target_predictor: RTL and testbench

- Parametrised dynamic branch predictor and branch target buffer for the next-generation 5-stage pipeline.
- Replaces static predict-not-taken, which costs a full flush on every taken branch.
- Looks up the fetch PC in the same cycle the instruction memory is read, returning a predicted direction and target for the PC mux.
- Trained from branch resolution in EX/MEM; flags mispredicts so the pipeline flushes IF/ID and ID/EX only when needed.

---
 rtl/branch_target_predictor.sv | 106 ++++++++++
 tb/tb_branch_target_predictor.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters and hit/mispredict statistics.
// Latency: 0-cycle lookup, table trained on the next edge; backpressure: none, an update is accepted every cycle.
module branch_target_predictor #(
    parameter int         XLEN     = 64,
    parameter int         ENTRIES  = 16,
    parameter logic [1:0] CTR_INIT = 2'b01,
    parameter int         CNTW     = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] fetchPC,
    output logic            predTaken,
    output logic [XLEN-1:0] predTarget,
    input  logic            updValid,
    input  logic [XLEN-1:0] updPC,
    input  logic            updTaken,
    input  logic [XLEN-1:0] updTarget,
    input  logic            updPredTaken,
    input  logic [XLEN-1:0] updPredTarget,
    output logic            mispredict,
    output logic [CNTW-1:0] hitCount,
    output logic [CNTW-1:0] missCount
);

    localparam int IDXW = $clog2(ENTRIES);
    localparam int TAGW = XLEN - IDXW - 2;

    logic            valid_q  [ENTRIES];
    logic [TAGW-1:0] tag_q    [ENTRIES];
    logic [XLEN-1:0] target_q [ENTRIES];
    logic [1:0]      ctr_q    [ENTRIES];

    logic [IDXW-1:0] fetch_idx;
    logic [TAGW-1:0] fetch_tag;
    logic            fetch_hit;
    logic [IDXW-1:0] upd_idx;
    logic [TAGW-1:0] upd_tag;
    logic            upd_hit;
    logic [1:0]      upd_ctr;
    logic [1:0]      upd_ctr_next;
    logic            unused_pc_bits;

    // Byte offset within an instruction word carries no prediction information.
    assign unused_pc_bits = ^{fetchPC[1:0], updPC[1:0]};

    assign fetch_idx = fetchPC[IDXW+1:2];
    assign fetch_tag = fetchPC[XLEN-1:IDXW+2];
    assign fetch_hit = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);

    assign predTaken  = fetch_hit && ctr_q[fetch_idx][1];
    assign predTarget = predTaken ? target_q[fetch_idx] : '0;

    assign upd_idx = updPC[IDXW+1:2];
    assign upd_tag = updPC[XLEN-1:IDXW+2];
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign upd_ctr = ctr_q[upd_idx];

    assign mispredict = updValid &&
                        ((updTaken != updPredTaken) ||
                         (updTaken && (updTarget != updPredTarget)));

    always_comb begin
        upd_ctr_next = upd_ctr;
        if (updTaken) begin
            if (upd_ctr != 2'b11) upd_ctr_next = upd_ctr + 2'b01;
        end else begin
            if (upd_ctr != 2'b00) upd_ctr_next = upd_ctr - 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_INIT;
            end
        end else if (updValid) begin
            if (upd_hit) begin
                ctr_q[upd_idx] <= upd_ctr_next;
                if (updTaken) target_q[upd_idx] <= updTarget;
            end else if (updTaken) begin
                // Allocation evicts whatever branch aliased into this slot.
                valid_q[upd_idx]  <= 1'b1;
                tag_q[upd_idx]    <= upd_tag;
                target_q[upd_idx] <= updTarget;
                ctr_q[upd_idx]    <= 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hitCount  <= '0;
            missCount <= '0;
        end else if (updValid) begin
            if (mispredict) begin
                if (missCount != {CNTW{1'b1}}) missCount <= missCount + 1'b1;
            end else begin
                if (hitCount != {CNTW{1'b1}}) hitCount <= hitCount + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed plus randomized bench for branch_target_predictor against an array-based reference model.
// A second instance with 4-bit statistics shares all inputs to exercise counter saturation.
module tb_branch_target_predictor;

    logic        clk = 1'b0;
    logic        reset, updValid, updTaken, updPredTaken;
    logic [63:0] fetchPC, updPC, updTarget, updPredTarget;

    logic        pt_a, mp_a, pt_b, mp_b;
    logic [63:0] tg_a, tg_b;
    logic [31:0] hc_a, mc_a;
    logic [3:0]  hc_b, mc_b;

    int checks   = 0;
    int failures = 0;

    // Reference model: slot = word address mod 16, tag = everything above the slot bits.
    bit          m_valid [16];
    logic [63:0] m_tag   [16];
    logic [63:0] m_tgt   [16];
    int          m_ctr   [16];
    longint      m_hit, m_miss;

    logic [63:0] pool [6];

    always #5 clk = ~clk;

    branch_target_predictor #(.XLEN(64), .ENTRIES(16), .CTR_INIT(2'b01), .CNTW(32)) dut_a (
        .clk(clk), .reset(reset), .fetchPC(fetchPC), .predTaken(pt_a), .predTarget(tg_a),
        .updValid(updValid), .updPC(updPC), .updTaken(updTaken), .updTarget(updTarget),
        .updPredTaken(updPredTaken), .updPredTarget(updPredTarget), .mispredict(mp_a),
        .hitCount(hc_a), .missCount(mc_a)
    );

    branch_target_predictor #(.XLEN(64), .ENTRIES(16), .CTR_INIT(2'b01), .CNTW(4)) dut_b (
        .clk(clk), .reset(reset), .fetchPC(fetchPC), .predTaken(pt_b), .predTarget(tg_b),
        .updValid(updValid), .updPC(updPC), .updTaken(updTaken), .updTarget(updTarget),
        .updPredTaken(updPredTaken), .updPredTarget(updPredTarget), .mispredict(mp_b),
        .hitCount(hc_b), .missCount(mc_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] sat(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? 64'(mx) : 64'(v);
    endfunction

    function automatic int slot(input logic [63:0] pc);
        return int'((pc >> 2) & 64'd15);
    endfunction

    function automatic void m_lookup(input logic [63:0] pc, output logic t, output logic [63:0] tg);
        int s;
        s  = slot(pc);
        t  = m_valid[s] && (m_tag[s] == (pc >> 6)) && (m_ctr[s] >= 2);
        tg = t ? m_tgt[s] : 64'd0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0;
            m_ctr[i]   = 1;
        end
        m_hit  = 0;
        m_miss = 0;
    endtask

    // One clock cycle: drive, check combinational and count outputs, advance model on the edge.
    task automatic step(input logic rst, input logic uv, input logic [63:0] fpc,
                        input logic [63:0] upc, input logic ut, input logic [63:0] utg,
                        input logic upt, input logic [63:0] uptg,
                        output logic obs_pt, output logic obs_mp);
        logic        et, emp, hit;
        logic [63:0] etg;
        int          s;
        reset = rst; updValid = uv; fetchPC = fpc; updPC = upc;
        updTaken = ut; updTarget = utg; updPredTaken = upt; updPredTarget = uptg;
        #1;
        m_lookup(fpc, et, etg);
        emp = uv && ((ut != upt) || (ut && (utg != uptg)));
        obs_pt = pt_a;
        obs_mp = mp_a;
        chk("predTaken", pt_a, et);
        chk("predTarget", tg_a, etg);
        chk("mispredict", mp_a, emp);
        chk("predTaken_b", pt_b, et);
        chk("mispredict_b", mp_b, emp);
        chk("hitCount", hc_a, sat(m_hit, 32));
        chk("missCount", mc_a, sat(m_miss, 32));
        chk("hitCount_b", hc_b, sat(m_hit, 4));
        chk("missCount_b", mc_b, sat(m_miss, 4));
        @(posedge clk);
        if (rst) begin
            m_reset();
        end else if (uv) begin
            if (emp) m_miss++; else m_hit++;
            s   = slot(upc);
            hit = m_valid[s] && (m_tag[s] == (upc >> 6));
            if (hit) begin
                if (ut) begin
                    m_ctr[s] = (m_ctr[s] < 3) ? m_ctr[s] + 1 : 3;
                    m_tgt[s] = utg;
                end else begin
                    m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
                end
            end else if (ut) begin
                m_valid[s] = 1;
                m_tag[s]   = upc >> 6;
                m_tgt[s]   = utg;
                m_ctr[s]   = 2;
            end
        end
        @(negedge clk);
    endtask

    task automatic probe(input string tag, input logic [63:0] fpc, input logic et, input logic [63:0] etg);
        reset = 1'b0; updValid = 1'b0; fetchPC = fpc;
        #1;
        chk({tag, "_taken"}, pt_a, et);
        chk({tag, "_target"}, tg_a, etg);
    endtask

    initial begin
        logic        opt, omp, rt, ut, upt;
        logic [63:0] fpc, upc, utg, uptg, rtg;

        pool[0] = 64'h40;   pool[1] = 64'h44;  pool[2] = 64'h80;
        pool[3] = 64'hC0;   pool[4] = 64'h1040; pool[5] = 64'h7C;
        m_reset();
        reset = 1'b1; updValid = 1'b0; fetchPC = '0; updPC = '0;
        updTaken = 1'b0; updTarget = '0; updPredTaken = 1'b0; updPredTarget = '0;
        @(negedge clk);

        // Reset state
        step(1, 0, 64'h0, 64'h0, 0, 64'h0, 0, 64'h0, opt, omp);
        probe("reset_lookup", 64'h40, 0, 64'h0);
        chk("reset_hit", hc_a, 0);
        chk("reset_miss", mc_a, 0);

        // First taken update allocates with counter 10
        step(0, 1, 64'h40, 64'h40, 1, 64'h100, 0, 64'h0, opt, omp);
        chk("alloc_mispredict", omp, 1);
        chk("same_cycle_no_bypass", opt, 0);
        probe("after_alloc", 64'h40, 1, 64'h100);
        chk("alloc_miss", mc_a, 1);

        // Saturate up, walk down, saturate at 00, climb back
        step(0, 1, 64'h40, 64'h40, 1, 64'h100, 1, 64'h100, opt, omp);
        step(0, 1, 64'h40, 64'h40, 1, 64'h100, 1, 64'h100, opt, omp);
        chk("two_hits", hc_a, 2);
        step(0, 1, 64'h40, 64'h40, 0, 64'h0, 1, 64'h100, opt, omp);
        step(0, 1, 64'h40, 64'h40, 0, 64'h0, 1, 64'h100, opt, omp);
        probe("ctr01", 64'h40, 0, 64'h0);
        step(0, 1, 64'h40, 64'h40, 0, 64'h0, 0, 64'h0, opt, omp);
        step(0, 1, 64'h40, 64'h40, 1, 64'h100, 0, 64'h0, opt, omp);
        probe("ctr_floor_then_01", 64'h40, 0, 64'h0);
        step(0, 1, 64'h40, 64'h40, 1, 64'h120, 0, 64'h0, opt, omp);
        probe("ctr10_new_target", 64'h40, 1, 64'h120);

        // Aliasing eviction
        step(0, 1, 64'h40, 64'h40, 1, 64'h100, 1, 64'h120, opt, omp);
        step(0, 1, 64'h80, 64'h80, 1, 64'h200, 0, 64'h0, opt, omp);
        probe("alias_old", 64'h40, 0, 64'h0);
        probe("alias_new", 64'h80, 1, 64'h200);

        // Not-taken miss does not allocate; target-only mispredict
        step(0, 1, 64'h44, 64'h44, 0, 64'h0, 0, 64'h0, opt, omp);
        probe("nt_no_alloc", 64'h44, 0, 64'h0);
        step(0, 1, 64'h44, 64'h44, 1, 64'h304, 1, 64'h300, opt, omp);
        chk("target_mispredict", omp, 1);
        probe("low_bits_ignored", 64'h47, 1, 64'h304);

        // Reset beats a same-cycle update
        step(1, 0, 64'h0, 64'h0, 0, 64'h0, 0, 64'h0, opt, omp);
        step(0, 1, 64'h40, 64'h40, 1, 64'h100, 0, 64'h0, opt, omp);
        chk("fresh_same_cycle", opt, 0);
        probe("fresh_next_cycle", 64'h40, 1, 64'h100);
        step(1, 1, 64'h0, 64'hC0, 1, 64'h500, 0, 64'h0, opt, omp);
        probe("reset_wins", 64'hC0, 0, 64'h0);
        probe("reset_clears", 64'h40, 0, 64'h0);
        chk("reset_wins_hit", hc_a, 0);
        chk("reset_wins_miss", mc_a, 0);

        // Small statistics counter saturates
        for (int i = 0; i < 20; i++) begin
            upc = pool[$urandom_range(0, 5)];
            step(0, 1, upc, upc, 1, 64'($urandom), 0, 64'h0, opt, omp);
        end
        chk("miss_sat_b", mc_b, 4'hF);
        chk("miss_nosat_a", mc_a, 20);

        // Randomized traffic, predictions mostly carried from the model as a pipeline would
        for (int i = 0; i < 400; i++) begin
            fpc = pool[$urandom_range(0, 5)] | 64'($urandom_range(0, 3));
            upc = pool[$urandom_range(0, 5)] | 64'($urandom_range(0, 3));
            ut  = 1'($urandom_range(0, 1));
            utg = ($urandom_range(0, 1) == 1) ? 64'h100 : {32'h0, $urandom} & ~64'h3;
            if ($urandom_range(0, 3) != 0) begin
                m_lookup(upc, rt, rtg);
                upt = rt; uptg = rtg;
            end else begin
                upt = 1'($urandom_range(0, 1)); uptg = 64'h100;
            end
            step((i == 200) ? 1'b1 : 1'b0, 1'($urandom_range(0, 4) != 0), fpc, upc, ut, utg,
                 upt, uptg, opt, omp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
